// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache miss/write-back port: serves whole 128-bit
// lines from a 32-bit word array, one word per beat after a fixed access latency.
package cache_mem_pkg;
    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;
endpackage

module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 512,
    parameter int unsigned LATENCY   = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  mem_req_type  mem_req_i,
    output mem_data_type mem_data_o,
    output logic         busy_o,
    output logic         drop_o,
    output logic [31:0]  rd_cnt_o,
    output logic [31:0]  wr_cnt_o
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           w_accept;
    logic           w_drop;
    logic [WW-1:0]  r_wait;
    logic [1:0]     r_beat;
    logic [27:0]    r_addr;
    logic           r_rw;
    logic [127:0]   r_data;
    logic [127:0]   r_line;
    logic           r_busy;
    logic           r_drop;
    logic [31:0]    r_rd_cnt;
    logic [31:0]    r_wr_cnt;
    logic [31:0]    r_mem [MEM_WORDS];
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_rdata;
    logic           w_wr_beat;
    logic           w_unused;

    // Line offset bits never matter: every transfer is a whole aligned line.
    assign w_unused = &{1'b0, mem_req_i.addr[3:0]};

    // Address bits above the array depth drop out here, so aliases share a line.
    assign w_idx     = AW'({r_addr, r_beat});
    assign w_rdata   = r_mem[w_idx];
    assign w_wr_beat = (r_state == S_XFER) && r_rw;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = mem_req_i.valid;
            end
            S_WAIT: begin
                w_drop = mem_req_i.valid;
                if (32'(r_wait) + 32'd1 >= LATENCY) begin
                    w_next = S_XFER;
                end
            end
            S_XFER: begin
                w_drop = mem_req_i.valid;
                if (r_beat == 2'd3) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_accept = mem_req_i.valid;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_accept) begin
            w_next = (LATENCY == 0) ? S_XFER : S_WAIT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_wait   <= '0;
            r_beat   <= '0;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_data   <= '0;
            r_line   <= '0;
            r_busy   <= 1'b0;
            r_drop   <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_WAIT) || (w_next == S_XFER);

            if ((r_state == S_WAIT) && (w_next == S_WAIT)) begin
                r_wait <= r_wait + WW'(1);
            end else begin
                r_wait <= '0;
            end

            if (r_state == S_XFER) begin
                r_beat <= r_beat + 2'd1;
            end else begin
                r_beat <= '0;
            end

            if (w_accept) begin
                r_addr <= mem_req_i.addr[31:4];
                r_rw   <= mem_req_i.rw;
                r_data <= mem_req_i.data;
            end

            if ((r_state == S_XFER) && !r_rw) begin
                r_line[{r_beat, 5'b0} +: 32] <= w_rdata;
            end

            if (w_drop) begin
                r_drop <= 1'b1;
            end

            if (r_state == S_RESP) begin
                if (r_rw) begin
                    r_wr_cnt <= r_wr_cnt + 32'd1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 32'd1;
                end
            end
        end
    end

    // Storage has no reset: contents survive rst_i, and an aborted write keeps
    // whatever beats already landed because the write enable follows r_state.
    always_ff @(posedge clk_i) begin
        if (w_wr_beat) begin
            r_mem[w_idx] <= r_data[{r_beat, 5'b0} +: 32];
        end
    end

    assign mem_data_o.data  = r_line;
    assign mem_data_o.ready = (r_state == S_RESP);
    assign busy_o           = r_busy;
    assign drop_o           = r_drop;
    assign rd_cnt_o         = r_rd_cnt;
    assign wr_cnt_o         = r_wr_cnt;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed table, multi-cycle corner
// sequences, and randomized traffic against a line-level reference model.
module tb_cache_mem_responder;
    import cache_mem_pkg::*;

    localparam int unsigned LAT    = 4;
    localparam int unsigned WORDS  = 512;
    localparam int unsigned WORDS0 = 64;
    localparam int          BUDGET = 40;

    localparam logic [127:0] D1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    localparam logic [127:0] D3 = 128'hA5A5_5A5A_0F0F_F0F0_1234_8765_FFFF_0001;
    localparam logic [127:0] D4 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [127:0] D5 = 128'hCAFE_0005_CAFE_0004_CAFE_0003_CAFE_0002;
    localparam logic [127:0] DR = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    localparam logic [127:0] DR_EXP = 128'h0000_0000_0000_0000_BBBB_BBBB_AAAA_AAAA;

    logic         clk = 1'b0;
    logic         rst;
    mem_req_type  req, req0;
    mem_data_type rsp, rsp0;
    logic         busy, drop, busy0, drop0;
    logic [31:0]  rdc, wrc, rdc0, wrc0;

    int n_vec = 0;
    int n_bad = 0;

    bit [127:0] mdl [int];
    int         m_rd = 0;
    int         m_wr = 0;
    bit [127:0] m_last = '0;

    always #5 clk = ~clk;

    cache_mem_responder #(.MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req), .mem_data_o(rsp),
        .busy_o(busy), .drop_o(drop), .rd_cnt_o(rdc), .wr_cnt_o(wrc)
    );

    cache_mem_responder #(.MEM_WORDS(WORDS0), .LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req0), .mem_data_o(rsp0),
        .busy_o(busy0), .drop_o(drop0), .rd_cnt_o(rdc0), .wr_cnt_o(wrc0)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic [127:0] exp_data;
        int           exp_cyc;
        int           exp_rd;
        int           exp_wr;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(input bit [31:0] a);
        return int'((a >> 4) % (WORDS / 4));
    endfunction

    // Line-granular memory model: writes store a line, reads fetch it; the
    // visible response data only changes on reads.
    function automatic bit [127:0] model(input bit [31:0] a, input bit [127:0] d, input bit rw);
        int ln;
        ln = line_of(a);
        if (rw) begin
            mdl[ln] = d;
            m_wr++;
        end else begin
            m_last = mdl.exists(ln) ? mdl[ln] : '0;
            m_rd++;
        end
        return m_last;
    endfunction

    // Drives a one-cycle request in the current cycle (cycle 0) and returns in
    // the cycle ready is seen, or after BUDGET cycles.
    task automatic txn(input logic [31:0] a, input logic [127:0] d, input logic rw,
                       output logic [127:0] got, output int ncyc);
        req.addr  = a;
        req.data  = d;
        req.rw    = rw;
        req.valid = 1'b1;
        step();
        req.valid = 1'b0;
        ncyc = 1;
        while (!rsp.ready && ncyc < BUDGET) begin
            step();
            ncyc++;
        end
        got = rsp.data;
    endtask

    task automatic lat0_txn(input logic [31:0] a, input logic [127:0] d, input logic rw,
                            input logic [127:0] exp_data);
        req0.addr  = a;
        req0.data  = d;
        req0.rw    = rw;
        req0.valid = 1'b1;
        step();
        req0.valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("lat0_busy_c%0d", c), 128'(busy0), 128'((c >= 1) && (c <= 4)));
            chk($sformatf("lat0_ready_c%0d", c), 128'(rsp0.ready), 128'(c == 5));
            if (c == 5) chk("lat0_data", rsp0.data, exp_data);
            if (c < 7) step();
        end
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] exp;
        logic [31:0]  a;
        logic [127:0] d;
        logic         rw;
        int           ncyc;
        int           pulses;
        int           ready_c;
        logic [127:0] drop_data;
        int           pool [8];

        tbl[0] = '{32'h0000_0040, D1,    1'b1, '0, 9, 0, 1};
        tbl[1] = '{32'h0000_004C, '0,    1'b0, D1, 9, 1, 1};
        tbl[2] = '{32'h0000_0800, D2,    1'b1, D1, 9, 1, 2};
        tbl[3] = '{32'h0000_0000, '0,    1'b0, D2, 9, 2, 2};
        tbl[4] = '{32'h0000_1230, D3,    1'b1, D2, 9, 2, 3};
        tbl[5] = '{32'h0000_0230, '0,    1'b0, D3, 9, 3, 3};
        pool   = '{8'h10, 8'h11, 8'h20, 8'h7F, 8'h03, 8'h55, 8'h66, 8'h01};

        rst  = 1'b1;
        req  = '0;
        req0 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data", rsp, '0);
        chk("reset_busy", 128'(busy), '0);
        chk("reset_drop", 128'(drop), '0);
        chk("reset_cnts", {rdc, wrc}, '0);
        rst = 1'b0;
        step();

        // Zero-latency instance: ready in cycle 5, busy only in cycles 1..4.
        lat0_txn(32'h0000_0020, D5, 1'b1, '0);
        lat0_txn(32'h0000_0020, '0, 1'b0, D5);
        step();
        chk("lat0_cnts", {rdc0, wrc0}, {32'd1, 32'd1});
        chk("lat0_drop", 128'(drop0), '0);

        for (int i = 0; i < 6; i++) begin
            void'(model(tbl[i].addr, tbl[i].data, tbl[i].rw));
            txn(tbl[i].addr, tbl[i].data, tbl[i].rw, got, ncyc);
            chk($sformatf("tbl%0d_cycle", i), 128'(ncyc), 128'(tbl[i].exp_cyc));
            chk($sformatf("tbl%0d_data", i), got, tbl[i].exp_data);
            step();
            chk($sformatf("tbl%0d_busy", i), 128'(busy), '0);
            chk($sformatf("tbl%0d_cnts", i), {rdc, wrc},
                {32'(tbl[i].exp_rd), 32'(tbl[i].exp_wr)});
        end

        // Write-back then allocate read issued in the write's RESP cycle.
        void'(model(32'h0000_0500, D4, 1'b1));
        txn(32'h0000_0500, D4, 1'b1, got, ncyc);
        chk("b2b_wr_cycle", 128'(ncyc), 128'(LAT + 5));
        exp = model(32'h0000_004C, '0, 1'b0);
        txn(32'h0000_004C, '0, 1'b0, got, ncyc);
        chk("b2b_rd_cycle", 128'(ncyc), 128'(LAT + 5));
        chk("b2b_rd_data", got, D1);
        chk("b2b_model", exp, D1);
        step();
        chk("b2b_drop", 128'(drop), '0);
        chk("b2b_cnts", {rdc, wrc}, {32'd4, 32'd4});

        // Second request during WAIT is dropped and must not touch line 0.
        void'(model(32'h0000_0040, '0, 1'b0));
        req.addr  = 32'h0000_0040;
        req.data  = '0;
        req.rw    = 1'b0;
        req.valid = 1'b1;
        step();
        req.valid = 1'b0;
        step();
        step();
        chk("drop_pre", 128'(drop), '0);
        req.addr  = 32'h0000_0800;
        req.data  = {4{32'hBAD0_BAD0}};
        req.rw    = 1'b1;
        req.valid = 1'b1;
        step();
        req.valid = 1'b0;
        chk("drop_set", 128'(drop), 128'(1));
        pulses    = 0;
        ready_c   = -1;
        drop_data = '0;
        for (int c = 4; c <= 25; c++) begin
            if (rsp.ready) begin
                pulses++;
                if (ready_c < 0) begin
                    ready_c   = c;
                    drop_data = rsp.data;
                end
            end
            if (c < 25) step();
        end
        chk("drop_pulses", 128'(pulses), 128'(1));
        chk("drop_ready_cycle", 128'(ready_c), 128'(LAT + 5));
        chk("drop_data", drop_data, D1);
        chk("drop_sticky", 128'(drop), 128'(1));
        chk("drop_cnts", {rdc, wrc}, {32'd5, 32'd4});
        exp = model(32'h0000_0000, '0, 1'b0);
        txn(32'h0000_0000, '0, 1'b0, got, ncyc);
        chk("drop_line0_data", got, exp);
        step();

        // Reset during beat 2 of a write over a zeroed line.
        void'(model(32'h0000_0300, '0, 1'b1));
        txn(32'h0000_0300, '0, 1'b1, got, ncyc);
        step();
        req.addr  = 32'h0000_0300;
        req.data  = DR;
        req.rw    = 1'b1;
        req.valid = 1'b1;
        step();
        req.valid = 1'b0;
        repeat (6) step();
        chk("rstw_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("rstw_data", rsp, '0);
        chk("rstw_busy", 128'(busy), '0);
        chk("rstw_drop", 128'(drop), '0);
        chk("rstw_cnts", {rdc, wrc}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        mdl[line_of(32'h0000_0300)] = DR_EXP;
        m_rd   = 0;
        m_wr   = 0;
        m_last = '0;
        exp = model(32'h0000_0300, '0, 1'b0);
        txn(32'h0000_0300, '0, 1'b0, got, ncyc);
        chk("rstw_read_cycle", 128'(ncyc), 128'(LAT + 5));
        chk("rstw_read_data", got, DR_EXP);
        chk("rstw_model", exp, DR_EXP);
        step();

        // Randomized traffic over a small pool of lines with aliased addresses.
        for (int i = 0; i < 8; i++) begin
            a = ($urandom() << 11) | (32'(pool[i]) << 4) | ($urandom() & 32'hF);
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp = model(a, d, 1'b1);
            txn(a, d, 1'b1, got, ncyc);
            chk($sformatf("rnd_init%0d_cycle", i), 128'(ncyc), 128'(LAT + 5));
            chk($sformatf("rnd_init%0d_data", i), got, exp);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            int gap;
            a   = ($urandom() << 11) | (32'(pool[$urandom_range(0, 7)]) << 4) | ($urandom() & 32'hF);
            d   = {$urandom(), $urandom(), $urandom(), $urandom()};
            rw  = 1'($urandom_range(0, 1));
            exp = model(a, d, rw);
            txn(a, d, rw, got, ncyc);
            chk($sformatf("rnd%0d_cycle", i), 128'(ncyc), 128'(LAT + 5));
            chk($sformatf("rnd%0d_data", i), got, exp);
            gap = $urandom_range(0, 2);
            repeat (gap) step();
        end
        step();
        chk("rnd_cnts", {rdc, wrc}, {32'(m_rd), 32'(m_wr)});
        chk("rnd_drop", 128'(drop), '0);
        chk("rnd_busy", 128'(busy), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Main-memory responder on the far side of the cache-to-memory interface. It accepts single-cycle line requests (`mem_req_type`: addr, 128-bit data, rw, valid) issued by the cache controller on a miss or a dirty write-back. It serves each request from an internal 32-bit-wide word array, transferring one word per beat over four beats after a programmable access latency. It then returns a one-cycle `ready` pulse with the line on `mem_data_type`, and keeps read/write/drop statistics for the performance counters.

## Interface
- MEM_WORDS, 512: depth of the word array in 32-bit words (2 KiB); power of two, ≥ 4.
- LATENCY, 4: wait cycles inserted before the first beat; 0 is legal.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset; one clock, asynchronous and active-high.
- mem_req_i  in  mem_req_type  request from the cache: addr[31:0], data[127:0], rw (1 = write), valid.
- mem_data_o  out  mem_data_type  response: data[127:0], ready.
- busy_o  out  1  high in WAIT and XFER.
- drop_o  out  1  sticky flag; set when a request is dropped.
- rd_cnt_o  out  32  completed line reads.
- wr_cnt_o  out  32  completed line writes.

## Operation
- States: IDLE, WAIT, XFER, RESP.
- Request acceptance:
  - Accept when `mem_req_i.valid` = 1 while in IDLE or RESP.
  - Acceptance in RESP is mandatory: the cache issues the allocate read in the same cycle it sees the write-back `ready`.
  - Accepting captures addr[31:4], rw and data[127:0] into request registers.
  - Next state is WAIT, or XFER when LATENCY = 0.
- Dropped requests: valid in WAIT or XFER is not captured, sets drop_o, and has no other effect.
- WAIT: counts LATENCY cycles, then goes to XFER with beat counter = 0.
- XFER: four cycles, beat b = 0..3.
  - Word index = {addr[log2(MEM_WORDS)+1:4], b}, i.e. modulo MEM_WORDS; higher address bits are ignored.
  - addr[3:0] is ignored; all transfers are whole aligned lines.
  - Read: line_q[32b+31:32b] ← array[index]. The array read is combinational; the capture into line_q is registered.
  - Write: array[index] ← req_data[32b+31:32b] on the clock edge.
  - After beat 3, go to RESP.
- RESP: lasts one cycle.
  - mem_data_o.ready = 1.
  - mem_data_o.data = line_q.
  - The matching counter (rd_cnt_o or wr_cnt_o) increments, wrapping modulo 2^32.
  - Next state is WAIT/XFER if a new request is accepted this cycle, else IDLE.
- mem_data_o.data:
  - Updated only by read beats.
  - Holds its value across write transactions and across idle cycles.
- The word array is not cleared by reset; its contents persist across reset.

## Timing
- Request in cycle 0 (valid sampled at the end of cycle 0):
  - WAIT in cycles 1..LATENCY.
  - XFER in cycles LATENCY+1..LATENCY+4.
  - ready in cycle LATENCY+5; with the default this is cycle 9.
- ready is high for exactly one cycle per accepted request. It never asserts without a prior accepted request.
- Back-to-back: a request accepted in the RESP cycle starts WAIT in the next cycle. Throughput is one line per LATENCY+5 cycles.
- Write-then-read of the same line: the read returns the newly written data, because all write beats complete before RESP.
- Reset (any cycle, asynchronous):
  - State is IDLE and the beat/wait counters are 0.
  - mem_data_o is all zeros, with ready = 0.
  - busy_o = 0, drop_o = 0, rd_cnt_o = 0, wr_cnt_o = 0.
  - A write interrupted mid-XFER leaves the beats already written in the array; the remaining words are unchanged.
  - No response is produced for the aborted request.
- busy_o is registered; it is low in IDLE and RESP.

## Test plan
- Write then read, LATENCY=4: write addr 0x0000_0040, data 0x4444_4444_3333_3333_2222_2222_1111_1111.
  - ready must pulse in cycle 9 with rw=1.
  - A read of 0x0000_004C then returns the same 128 bits, ready in cycle 9, words in order 1111…/2222…/3333…/4444… at bits [31:0]..[127:96].
  - Afterwards rd_cnt_o = 1 and wr_cnt_o = 1.
- Write-back followed by allocate: write line A, then assert a read of line B in the exact RESP cycle of A.
  - Read B must be accepted with no idle cycle; its ready comes LATENCY+5 cycles after the RESP cycle of A.
  - drop_o must stay 0.
- Drop: issue a read, then assert valid again in cycle 3 (WAIT).
  - Exactly one ready pulse results.
  - drop_o = 1 from cycle 4.
  - rd_cnt_o = 1.
- Address wrap, MEM_WORDS=512: write 0x0000_0800, then read 0x0000_0000. The read returns the written line, since both aliases map to index 0.
- LATENCY=0: a read in cycle 0 gives ready in cycle 5. busy_o is high in cycles 1–4 only.
- Reset mid-write: assert rst_i during beat 2 of a write of 0xDDDD…_CCCC…_BBBB…_AAAA… over a line holding zeros.
  - All outputs must be zero immediately.
  - A subsequent read of that line returns words 0 and 1 as AAAA…/BBBB… and words 2 and 3 as 0.
